// File: rtl/id_ctrl_if.sv
// ID-stage to ID/EX control bus: instruction in, stall out, registered EX control out.
interface id_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      id_inst;
    logic             id_valid;
    logic             pipe_hold;
    logic             ex_flush;
    logic             id_stall;
    logic             ex_valid;
    logic [1:0]       ex_wd_sel;
    logic [3:0]       ex_alu_op;
    logic             ex_alua_pc;
    logic             ex_alub_sel;
    logic             ex_rf_we;
    logic             ex_dram_we;
    logic [2:0]       ex_sext_op;
    logic [2:0]       ex_branch;
    logic [1:0]       ex_jump;
    logic [4:0]       ex_rd;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic             ex_illegal;
    logic [CNT_W-1:0] perf_stalls;

    modport master (
        output id_inst, id_valid, pipe_hold, ex_flush,
        input  id_stall, ex_valid, ex_wd_sel, ex_alu_op, ex_alua_pc, ex_alub_sel, ex_rf_we,
               ex_dram_we, ex_sext_op, ex_branch, ex_jump, ex_rd, ex_rs1, ex_rs2, ex_illegal,
               perf_stalls
    );

    modport slave (
        input  id_inst, id_valid, pipe_hold, ex_flush,
        output id_stall, ex_valid, ex_wd_sel, ex_alu_op, ex_alua_pc, ex_alub_sel, ex_rf_we,
               ex_dram_we, ex_sext_op, ex_branch, ex_jump, ex_rd, ex_rs1, ex_rs2, ex_illegal,
               perf_stalls
    );
endinterface

// File: rtl/id_ctrl_stage.sv
// ID-stage decoder with RAW hazard scoreboard driving the registered ID/EX control word.
module id_ctrl_stage #(
    parameter bit          FWD_EN    = 1'b1,
    parameter int unsigned HAZ_DEPTH = 3,
    parameter bit          EN_SLT    = 1'b1,
    parameter bit          EN_AUIPC  = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input logic     clk,
    input logic     rst,
    id_ctrl_if.slave bus
);
    localparam logic [1:0] WD_ALU  = 2'd0, WD_DRAM = 2'd1, WD_PC4 = 2'd2, WD_EXT = 2'd3;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9;
    localparam logic [2:0] SEXT_I = 3'd0, SEXT_S = 3'd1, SEXT_B = 3'd2, SEXT_U = 3'd3, SEXT_J = 3'd4;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic       valid;
        logic [1:0] wd_sel;
        logic [3:0] alu_op;
        logic       alua_pc;
        logic       alub_sel;
        logic       rf_we;
        logic       dram_we;
        logic [2:0] sext_op;
        logic [2:0] branch;
        logic [1:0] jump;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic       v;
        logic       we;
        logic [4:0] rd;
        logic       ld;
    } sb_t;

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd, rs1, rs2;
    logic       f7_zero, f7_alt, is_r;

    ctrl_t          dec, idex, idex_n;
    sb_t            sb [HAZ_DEPTH];
    sb_t            sb_in;
    logic           re1, re2, legal;
    logic           match1, match2, hazard;
    logic [CNT_W-1:0] perf;

    assign op      = bus.id_inst[6:0];
    assign rd      = bus.id_inst[11:7];
    assign f3      = bus.id_inst[14:12];
    assign rs1     = bus.id_inst[19:15];
    assign rs2     = bus.id_inst[24:20];
    assign f7      = bus.id_inst[31:25];
    assign f7_zero = (f7 == 7'h00);
    assign f7_alt  = (f7 == 7'h20);
    assign is_r    = (op == OP_R);

    // Instruction decode; anything unsupported collapses to an illegal, side-effect-free word.
    always_comb begin
        dec   = '0;
        re1   = 1'b0;
        re2   = 1'b0;
        legal = 1'b0;
        case (op)
            OP_R, OP_I: begin
                re1          = 1'b1;
                re2          = is_r;
                dec.rf_we    = 1'b1;
                dec.alub_sel = !is_r;
                dec.sext_op  = SEXT_I;
                case (f3)
                    3'b000: begin dec.alu_op = (is_r && f7[5]) ? ALU_SUB : ALU_ADD;
                                  legal = !is_r || f7_zero || f7_alt; end
                    3'b001: begin dec.alu_op = ALU_SLL;  legal = f7_zero; end
                    3'b010: begin dec.alu_op = ALU_SLT;  legal = EN_SLT && (!is_r || f7_zero); end
                    3'b011: begin dec.alu_op = ALU_SLTU; legal = EN_SLT && (!is_r || f7_zero); end
                    3'b100: begin dec.alu_op = ALU_XOR;  legal = !is_r || f7_zero; end
                    3'b101: begin dec.alu_op = f7[5] ? ALU_SRA : ALU_SRL; legal = f7_zero || f7_alt; end
                    3'b110: begin dec.alu_op = ALU_OR;   legal = !is_r || f7_zero; end
                    3'b111: begin dec.alu_op = ALU_AND;  legal = !is_r || f7_zero; end
                endcase
            end
            OP_LD: begin
                legal = (f3 == 3'b010); re1 = 1'b1;
                dec.rf_we = 1'b1; dec.wd_sel = WD_DRAM; dec.alub_sel = 1'b1; dec.sext_op = SEXT_I;
            end
            OP_ST: begin
                legal = (f3 == 3'b010); re1 = 1'b1; re2 = 1'b1;
                dec.dram_we = 1'b1; dec.alub_sel = 1'b1; dec.sext_op = SEXT_S;
            end
            OP_BR: begin
                legal = (f3 != 3'b010) && (f3 != 3'b011); re1 = 1'b1; re2 = 1'b1;
                dec.branch = {f3[2], f3[0], 1'b1}; dec.alu_op = ALU_SUB; dec.sext_op = SEXT_B;
            end
            OP_JAL: begin
                legal = 1'b1;
                dec.rf_we = 1'b1; dec.wd_sel = WD_PC4; dec.jump = 2'b11; dec.sext_op = SEXT_J;
            end
            OP_JALR: begin
                legal = (f3 == 3'b000); re1 = 1'b1;
                dec.rf_we = 1'b1; dec.wd_sel = WD_PC4; dec.jump = 2'b01;
                dec.alub_sel = 1'b1; dec.sext_op = SEXT_I;
            end
            OP_LUI: begin
                legal = 1'b1;
                dec.rf_we = 1'b1; dec.wd_sel = WD_EXT; dec.sext_op = SEXT_U;
            end
            OP_AUIPC: begin
                legal = EN_AUIPC;
                dec.rf_we = 1'b1; dec.wd_sel = WD_ALU; dec.alua_pc = 1'b1;
                dec.alub_sel = 1'b1; dec.sext_op = SEXT_U;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            re1         = 1'b0;
            re2         = 1'b0;
        end
        dec.rd  = rd;
        dec.rs1 = rs1;
        dec.rs2 = rs2;
        if (rd == 5'd0) dec.rf_we = 1'b0;
        dec.valid = 1'b1;
    end

    // With forwarding only a load sitting in EX blocks; otherwise any in-flight writer does.
    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int k = 0; k < int'(HAZ_DEPTH); k++) begin
            if (sb[k].v && sb[k].we && (!FWD_EN || (k == 0 && sb[k].ld))) begin
                if (sb[k].rd == rs1) match1 = 1'b1;
                if (sb[k].rd == rs2) match2 = 1'b1;
            end
        end
        hazard = bus.id_valid && ((re1 && (rs1 != 5'd0) && match1) ||
                                  (re2 && (rs2 != 5'd0) && match2));
        idex_n = (bus.ex_flush || hazard || !bus.id_valid) ? '0 : dec;
        sb_in  = '{v: idex_n.valid, we: idex_n.rf_we, rd: idex_n.rd, ld: (idex_n.wd_sel == WD_DRAM)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex <= '0;
            perf <= '0;
            for (int k = 0; k < int'(HAZ_DEPTH); k++) sb[k] <= '0;
        end else if (!bus.pipe_hold) begin
            idex  <= idex_n;
            sb[0] <= sb_in;
            for (int k = 1; k < int'(HAZ_DEPTH); k++) sb[k] <= sb[k-1];
            if (!bus.ex_flush && hazard && (perf != '1)) perf <= perf + CNT_W'(1);
        end
    end

    assign bus.id_stall    = !rst && (bus.pipe_hold || (!bus.ex_flush && hazard));
    assign bus.ex_valid    = idex.valid;
    assign bus.ex_wd_sel   = idex.wd_sel;
    assign bus.ex_alu_op   = idex.alu_op;
    assign bus.ex_alua_pc  = idex.alua_pc;
    assign bus.ex_alub_sel = idex.alub_sel;
    assign bus.ex_rf_we    = idex.rf_we;
    assign bus.ex_dram_we  = idex.dram_we;
    assign bus.ex_sext_op  = idex.sext_op;
    assign bus.ex_branch   = idex.branch;
    assign bus.ex_jump     = idex.jump;
    assign bus.ex_rd       = idex.rd;
    assign bus.ex_rs1      = idex.rs1;
    assign bus.ex_rs2      = idex.rs2;
    assign bus.ex_illegal  = idex.illegal;
    assign bus.perf_stalls = perf;
endmodule

// File: tb/tb_id_ctrl_stage.sv
// Self-checking bench: decode table, directed hazard/flush/hold/reset sequences, random traffic vs model.
module tb_id_ctrl_stage;
    typedef struct packed {
        logic valid; logic [1:0] wd; logic [3:0] alu; logic apc; logic bsel; logic rfwe; logic dwe;
        logic [2:0] sext; logic [2:0] br; logic [1:0] jmp; logic [4:0] rd; logic [4:0] rs1;
        logic [4:0] rs2; logic ill;
    } ctl_t;
    typedef struct { logic [31:0] inst; logic re1; logic re2; ctl_t c; } vec_t;

    localparam logic [1:0] W_ALU = 2'd0, W_DRAM = 2'd1, W_PC4 = 2'd2, W_EXT = 2'd3;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4,
                           A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_SLT = 4'd8, A_SLTU = 4'd9;
    localparam logic [2:0] S_I = 3'd0, S_S = 3'd1, S_B = 3'd2, S_U = 3'd3, S_J = 3'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_d [3];
    logic [31:0] inst_d [3];
    logic        val_d [3], hold_d [3], flush_d [3];
    ctl_t        act [3];
    logic        stall_a [3];
    int unsigned perf_a [3];

    id_ctrl_if #(.CNT_W(16)) if0 ();
    id_ctrl_if #(.CNT_W(16)) if1 ();
    id_ctrl_if #(.CNT_W(2))  if2 ();

    id_ctrl_stage #(.FWD_EN(1'b1), .HAZ_DEPTH(3), .CNT_W(16)) u0 (.clk(clk), .rst(rst_d[0]), .bus(if0));
    id_ctrl_stage #(.FWD_EN(1'b0), .HAZ_DEPTH(3), .CNT_W(16)) u1 (.clk(clk), .rst(rst_d[1]), .bus(if1));
    id_ctrl_stage #(.FWD_EN(1'b0), .HAZ_DEPTH(3), .CNT_W(2))  u2 (.clk(clk), .rst(rst_d[2]), .bus(if2));

    assign if0.id_inst = inst_d[0]; assign if0.id_valid = val_d[0];
    assign if0.pipe_hold = hold_d[0]; assign if0.ex_flush = flush_d[0];
    assign if1.id_inst = inst_d[1]; assign if1.id_valid = val_d[1];
    assign if1.pipe_hold = hold_d[1]; assign if1.ex_flush = flush_d[1];
    assign if2.id_inst = inst_d[2]; assign if2.id_valid = val_d[2];
    assign if2.pipe_hold = hold_d[2]; assign if2.ex_flush = flush_d[2];

    assign act[0] = {if0.ex_valid, if0.ex_wd_sel, if0.ex_alu_op, if0.ex_alua_pc, if0.ex_alub_sel,
                     if0.ex_rf_we, if0.ex_dram_we, if0.ex_sext_op, if0.ex_branch, if0.ex_jump,
                     if0.ex_rd, if0.ex_rs1, if0.ex_rs2, if0.ex_illegal};
    assign act[1] = {if1.ex_valid, if1.ex_wd_sel, if1.ex_alu_op, if1.ex_alua_pc, if1.ex_alub_sel,
                     if1.ex_rf_we, if1.ex_dram_we, if1.ex_sext_op, if1.ex_branch, if1.ex_jump,
                     if1.ex_rd, if1.ex_rs1, if1.ex_rs2, if1.ex_illegal};
    assign act[2] = {if2.ex_valid, if2.ex_wd_sel, if2.ex_alu_op, if2.ex_alua_pc, if2.ex_alub_sel,
                     if2.ex_rf_we, if2.ex_dram_we, if2.ex_sext_op, if2.ex_branch, if2.ex_jump,
                     if2.ex_rd, if2.ex_rs1, if2.ex_rs2, if2.ex_illegal};
    assign stall_a[0] = if0.id_stall;
    assign stall_a[1] = if1.id_stall;
    assign stall_a[2] = if2.id_stall;
    assign perf_a[0] = 32'(if0.perf_stalls);
    assign perf_a[1] = 32'(if1.perf_stalls);
    assign perf_a[2] = 32'(if2.perf_stalls);

    int n_chk = 0;
    int n_fail = 0;

    // Model: per register, the advance-tick at which its latest writer entered EX.
    int   p_fwd [3]   = '{1, 0, 0};
    int   p_depth [3] = '{3, 3, 3};
    int   p_max [3]   = '{65535, 65535, 3};
    int   m_n [3];
    int   m_last [3][32];
    logic m_ld [3][32];
    int   m_perf [3];
    ctl_t m_c [3];

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    function automatic ctl_t mk(logic [31:0] i, logic [1:0] wd, logic [3:0] alu, logic apc,
                                logic bsel, logic rfwe, logic dwe, logic [2:0] sext,
                                logic [2:0] br, logic [1:0] jmp, logic ill);
        ctl_t c;
        c = '{valid: 1'b1, wd: wd, alu: alu, apc: apc, bsel: bsel, rfwe: rfwe, dwe: dwe, sext: sext,
              br: br, jmp: jmp, rd: i[11:7], rs1: i[19:15], rs2: i[24:20], ill: ill};
        return c;
    endfunction

    function automatic vec_t vr(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd, logic [4:0] a,
                                logic [4:0] b, logic [3:0] alu, logic ill);
        vec_t v;
        v.inst = {f7, b, a, f3, rd, 7'b0110011};
        v.re1 = !ill; v.re2 = !ill;
        v.c = ill ? mk(v.inst, W_ALU, A_ADD, 0, 0, 0, 0, S_I, 3'b0, 2'b0, 1)
                  : mk(v.inst, W_ALU, alu, 0, 0, rd != 0, 0, S_I, 3'b0, 2'b0, 0);
        return v;
    endfunction

    function automatic vec_t vi(logic [11:0] imm, logic [2:0] f3, logic [4:0] rd, logic [4:0] a,
                                logic [3:0] alu);
        vec_t v;
        v.inst = {imm, a, f3, rd, 7'b0010011};
        v.re1 = 1; v.re2 = 0;
        v.c = mk(v.inst, W_ALU, alu, 0, 1, rd != 0, 0, S_I, 3'b0, 2'b0, 0);
        return v;
    endfunction

    function automatic vec_t vlw(logic [4:0] rd, logic [4:0] a);
        vec_t v;
        v.inst = {12'h0, a, 3'b010, rd, 7'b0000011};
        v.re1 = 1; v.re2 = 0;
        v.c = mk(v.inst, W_DRAM, A_ADD, 0, 1, rd != 0, 0, S_I, 3'b0, 2'b0, 0);
        return v;
    endfunction

    function automatic vec_t vsw(logic [4:0] b, logic [4:0] a);
        vec_t v;
        v.inst = {7'h0, b, a, 3'b010, 5'h0, 7'b0100011};
        v.re1 = 1; v.re2 = 1;
        v.c = mk(v.inst, W_ALU, A_ADD, 0, 1, 0, 1, S_S, 3'b0, 2'b0, 0);
        return v;
    endfunction

    function automatic vec_t vbr(logic [2:0] f3, logic [4:0] a, logic [4:0] b);
        vec_t v;
        v.inst = {7'h0, b, a, f3, 5'h0, 7'b1100011};
        v.re1 = 1; v.re2 = 1;
        v.c = mk(v.inst, W_ALU, A_SUB, 0, 0, 0, 0, S_B, {f3[2], f3[0], 1'b1}, 2'b0, 0);
        return v;
    endfunction

    function automatic vec_t vu(logic [6:0] op, logic [4:0] rd);
        vec_t v;
        v.inst = {20'h12345, rd, op};
        v.re1 = 0; v.re2 = 0;
        if (op == 7'b0110111) v.c = mk(v.inst, W_EXT, A_ADD, 0, 0, rd != 0, 0, S_U, 3'b0, 2'b0, 0);
        else if (op == 7'b0010111) v.c = mk(v.inst, W_ALU, A_ADD, 1, 1, rd != 0, 0, S_U, 3'b0, 2'b0, 0);
        else v.c = mk(v.inst, W_PC4, A_ADD, 0, 0, rd != 0, 0, S_J, 3'b0, 2'b11, 0);
        return v;
    endfunction

    function automatic vec_t vjalr(logic [4:0] rd, logic [4:0] a);
        vec_t v;
        v.inst = {12'h0, a, 3'b000, rd, 7'b1100111};
        v.re1 = 1; v.re2 = 0;
        v.c = mk(v.inst, W_PC4, A_ADD, 0, 1, rd != 0, 0, S_I, 3'b0, 2'b01, 0);
        return v;
    endfunction

    function automatic vec_t vraw(logic [31:0] i);
        vec_t v;
        v.inst = i; v.re1 = 0; v.re2 = 0;
        v.c = mk(i, W_ALU, A_ADD, 0, 0, 0, 0, S_I, 3'b0, 2'b0, 1);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        logic [4:0] a, b, d;
        a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 5))
            0: return vr(7'h00, 3'b000, d, a, b, A_ADD, 0);
            1: return vi(12'h004, 3'b000, d, a, A_ADD);
            2: return vlw(d, a);
            3: return vsw(b, a);
            4: return vbr(3'b000, a, b);
            default: return vu(7'b0110111, d);
        endcase
    endfunction

    function automatic logic m_busy(int k, logic [4:0] r);
        int age;
        age = m_n[k] - m_last[k][r];
        return (p_fwd[k] != 0) ? (age == 0 && m_ld[k][r]) : (age < p_depth[k]);
    endfunction

    function automatic logic m_hazard(int k, vec_t v, logic valid);
        return valid && ((v.re1 && v.c.rs1 != 0 && m_busy(k, v.c.rs1)) ||
                         (v.re2 && v.c.rs2 != 0 && m_busy(k, v.c.rs2)));
    endfunction

    task automatic step(input int k, input vec_t v, input logic valid, input logic hold,
                        input logic flush, input logic r, output logic st);
        logic eh, es;
        inst_d[k] = v.inst; val_d[k] = valid; hold_d[k] = hold; flush_d[k] = flush; rst_d[k] = r;
        #2;
        eh = m_hazard(k, v, valid);
        es = !r && (hold || (!flush && eh));
        st = stall_a[k];
        chk($sformatf("u%0d id_stall", k), 64'(stall_a[k]), 64'(es));
        @(posedge clk);
        if (r) begin
            m_c[k] = '0; m_perf[k] = 0;
            for (int j = 0; j < 32; j++) m_last[k][j] = -100;
        end else if (!hold) begin
            m_n[k]++;
            if (flush || eh || !valid) m_c[k] = '0;
            else begin
                m_c[k] = v.c;
                if (v.c.rfwe) begin m_last[k][v.c.rd] = m_n[k]; m_ld[k][v.c.rd] = (v.c.wd == W_DRAM); end
            end
            if (!flush && eh && m_perf[k] < p_max[k]) m_perf[k]++;
        end
        #1;
        chk($sformatf("u%0d ex_ctrl", k), 64'(act[k]), 64'(m_c[k]));
        chk($sformatf("u%0d perf_stalls", k), 64'(perf_a[k]), 64'(m_perf[k]));
    endtask

    task automatic issue(input int k, input vec_t v, output int stalls);
        logic st;
        stalls = 0;
        for (int t = 0; t < 12; t++) begin
            step(k, v, 1'b1, 1'b0, 1'b0, 1'b0, st);
            if (!st) return;
            stalls++;
        end
        chk($sformatf("u%0d issue bound", k), 64'(stalls), 64'(0));
    endtask

    vec_t tbl [$];
    vec_t nop;

    initial begin
        logic st;
        int   ns;
        nop = vi(12'h0, 3'b000, 5'd0, 5'd0, A_ADD);
        for (int k = 0; k < 3; k++) begin
            rst_d[k] = 1; inst_d[k] = nop.inst; val_d[k] = 0; hold_d[k] = 0; flush_d[k] = 0;
            m_n[k] = 0; m_perf[k] = 0; m_c[k] = '0;
            for (int j = 0; j < 32; j++) begin m_last[k][j] = -100; m_ld[k][j] = 0; end
        end

        // Decode table on the forwarding instance.
        tbl = '{vr(7'h20, 3'b000, 5'd3, 5'd1, 5'd2, A_SUB, 0), vr(7'h00, 3'b111, 5'd4, 5'd1, 5'd2, A_AND, 0),
                vr(7'h00, 3'b110, 5'd5, 5'd1, 5'd2, A_OR, 0),  vr(7'h00, 3'b100, 5'd6, 5'd1, 5'd2, A_XOR, 0),
                vr(7'h00, 3'b001, 5'd7, 5'd1, 5'd2, A_SLL, 0), vr(7'h00, 3'b101, 5'd3, 5'd1, 5'd2, A_SRL, 0),
                vr(7'h20, 3'b101, 5'd4, 5'd1, 5'd2, A_SRA, 0), vr(7'h00, 3'b010, 5'd5, 5'd1, 5'd2, A_SLT, 0),
                vr(7'h00, 3'b011, 5'd6, 5'd1, 5'd2, A_SLTU, 0), vr(7'h01, 3'b000, 5'd3, 5'd1, 5'd2, A_ADD, 1),
                vi(12'h005, 3'b010, 5'd3, 5'd1, A_SLT),        vi(12'h403, 3'b101, 5'd4, 5'd1, A_SRA),
                vi(12'h004, 3'b000, 5'd0, 5'd1, A_ADD),         vlw(5'd8, 5'd1), vsw(5'd2, 5'd1),
                vbr(3'b000, 5'd1, 5'd2), vbr(3'b111, 5'd1, 5'd2), vu(7'b1101111, 5'd1), vjalr(5'd1, 5'd2),
                vu(7'b0110111, 5'd7), vu(7'b0010111, 5'd7), vraw(32'h0000_0073)};
        step(0, nop, 0, 0, 0, 1, st);
        for (int i = 0; i < tbl.size(); i++) issue(0, tbl[i], ns);

        // Load-use with forwarding: one bubble.
        step(0, nop, 0, 0, 0, 1, st);
        issue(0, vlw(5'd5, 5'd1), ns);
        issue(0, vr(7'h00, 3'b000, 5'd6, 5'd5, 5'd2, A_ADD, 0), ns);
        chk("loaduse stalls", 64'(ns), 64'(1));
        chk("loaduse ex_rd", 64'(act[0].rd), 64'(6));
        chk("loaduse perf", 64'(perf_a[0]), 64'(1));

        // Flush overrides the hazard stall.
        step(0, nop, 0, 0, 0, 1, st);
        issue(0, vlw(5'd5, 5'd1), ns);
        step(0, vr(7'h00, 3'b000, 5'd6, 5'd5, 5'd2, A_ADD, 0), 1, 0, 1, 0, st);
        chk("flush id_stall", 64'(st), 64'(0));
        chk("flush ex_valid", 64'(act[0].valid), 64'(0));
        chk("flush perf", 64'(perf_a[0]), 64'(0));

        // No forwarding: producer must drain the whole scoreboard.
        step(1, nop, 0, 0, 0, 1, st);
        issue(1, vi(12'h001, 3'b000, 5'd5, 5'd0, A_ADD), ns);
        issue(1, vr(7'h00, 3'b000, 5'd6, 5'd5, 5'd5, A_ADD, 0), ns);
        chk("nofwd stalls", 64'(ns), 64'(3));
        chk("nofwd perf", 64'(perf_a[1]), 64'(3));

        // x0 destination never creates a dependency.
        step(1, nop, 0, 0, 0, 1, st);
        issue(1, vi(12'h004, 3'b000, 5'd0, 5'd1, A_ADD), ns);
        chk("x0 rf_we", 64'(act[1].rfwe), 64'(0));
        issue(1, vr(7'h00, 3'b000, 5'd2, 5'd0, 5'd0, A_ADD, 0), ns);
        chk("x0 stalls", 64'(ns), 64'(0));

        // Hold for three cycles in the middle of a stall.
        step(1, nop, 0, 0, 0, 1, st);
        issue(1, vi(12'h001, 3'b000, 5'd5, 5'd0, A_ADD), ns);
        step(1, vr(7'h00, 3'b000, 5'd6, 5'd5, 5'd5, A_ADD, 0), 1, 0, 0, 0, st);
        for (int h = 0; h < 3; h++) begin
            step(1, vr(7'h00, 3'b000, 5'd6, 5'd5, 5'd5, A_ADD, 0), 1, 1, 0, 0, st);
            chk("hold perf", 64'(perf_a[1]), 64'(1));
        end
        issue(1, vr(7'h00, 3'b000, 5'd6, 5'd5, 5'd5, A_ADD, 0), ns);
        chk("hold remaining stalls", 64'(ns), 64'(2));
        chk("hold ex_rd", 64'(act[1].rd), 64'(6));

        // Saturating 2-bit counter, then reset in the middle of a stall.
        step(2, nop, 0, 0, 0, 1, st);
        issue(2, vi(12'h001, 3'b000, 5'd5, 5'd0, A_ADD), ns);
        issue(2, vr(7'h00, 3'b000, 5'd6, 5'd5, 5'd5, A_ADD, 0), ns);
        issue(2, vi(12'h001, 3'b000, 5'd7, 5'd0, A_ADD), ns);
        step(2, vr(7'h00, 3'b000, 5'd8, 5'd7, 5'd7, A_ADD, 0), 1, 0, 0, 0, st);
        step(2, vr(7'h00, 3'b000, 5'd8, 5'd7, 5'd7, A_ADD, 0), 1, 0, 0, 0, st);
        chk("sat perf", 64'(perf_a[2]), 64'(3));
        step(2, vr(7'h00, 3'b000, 5'd8, 5'd7, 5'd7, A_ADD, 0), 1, 0, 0, 1, st);
        chk("rst ex_ctrl zero", 64'(act[2]), 64'(0));
        chk("rst perf zero", 64'(perf_a[2]), 64'(0));
        issue(2, vr(7'h00, 3'b000, 5'd8, 5'd7, 5'd7, A_ADD, 0), ns);
        chk("post-rst stalls", 64'(ns), 64'(0));
        chk("post-rst ex_rd", 64'(act[2].rd), 64'(8));

        // Random traffic against the model on every instance.
        for (int k = 0; k < 3; k++) begin
            vec_t v;
            step(k, nop, 0, 0, 0, 1, st);
            v = rand_vec();
            for (int c = 0; c < 300; c++) begin
                if (!st) v = rand_vec();
                step(k, v, ($urandom % 10) != 0, ($urandom % 8) == 0, ($urandom % 10) == 0,
                     ($urandom % 60) == 0, st);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
